thread_sched: RTL and testbench

//  Multi-context successor of the single-thread sequencer: N_THREADS hardware contexts
//  (own pc, own 32-entry register file) share one unit port, one instruction at a time,

---
 rtl/thread_sched_if.sv | 35 +++
 rtl/thread_sched.sv | 199 +++++++++++++++++++
 tb/tb_thread_sched.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/thread_sched_if.sv
// Unit-port types and the request/acknowledge bundle between the thread scheduler and the RAM/ALU.
// Latency: wiring only; the scheduler drives the request side and the unit answers with ack/out.
// Backpressure: the unit holds ack low as long as it needs; sel/contr/in stay stable while req is high.
package thread_sched_pkg;
    typedef enum logic {
        UNIT_SEL_RAM = 1'b0,
        UNIT_SEL_ALU = 1'b1
    } unit_sel_t;

    localparam logic [31:0] RAM_CTRL_READ = 32'd0;
endpackage

interface thread_sched_if #(
    parameter int XLEN = 32
) ();
    import thread_sched_pkg::*;

    unit_sel_t        unit_sel;
    logic [XLEN-1:0]  unit_contr;
    logic [XLEN-1:0]  unit_in0;
    logic [XLEN-1:0]  unit_in1;
    logic             unit_req;
    logic             unit_ack;
    logic [XLEN-1:0]  unit_out;

    modport master (
        output unit_sel, unit_contr, unit_in0, unit_in1, unit_req,
        input  unit_ack, unit_out
    );

    modport slave (
        input  unit_sel, unit_contr, unit_in0, unit_in1, unit_req,
        output unit_ack, unit_out
    );
endinterface

// File: rtl/thread_sched.sv
// Round-robin multi-context sequencer: N contexts share one unit port, one instruction in flight.
// Latency: 4 cycles/instruction best case (select, fetch, execute, retire); more while ack is late.
// Backpressure: FETCH/EXEC hold req and all request fields stable until the unit acks.
module thread_sched
    import thread_sched_pkg::*;
#(
    parameter int              N_THREADS = 4,
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] PC_STRIDE = 'h1000,
    localparam int             TID_W     = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_THREADS-1:0] thread_en,
    thread_sched_if.master       unit,
    output logic [TID_W-1:0]     cur_tid,
    output logic                 retire,
    output logic [N_THREADS-1:0] halted
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        ST_SELECT,
        ST_FETCH,
        ST_EXEC,
        ST_RETIRE
    } state_t;

    state_t               state_q, state_d;
    logic [TID_W-1:0]     cur_tid_q, cur_tid_d;
    logic [TID_W-1:0]     rr_q, rr_d;
    logic [N_THREADS-1:0] halted_q, halted_d;
    logic [31:0]          inst_q, inst_d;
    logic [XLEN-1:0]      result_q, result_d;
    logic [XLEN-1:0]      pc_q [N_THREADS];
    logic [XLEN-1:0]      rf_q [N_THREADS][32];

    logic                 pc_inc;
    logic                 rf_we;

    unit_sel_t            u_sel;
    logic [XLEN-1:0]      u_contr, u_in0, u_in1;
    logic                 u_req;

    // Instruction fields of the latched instruction word.
    logic [6:0]           opcode;
    logic [4:0]           rd, rs1, rs2;
    logic [2:0]           funct3;
    logic [XLEN-1:0]      rs1_val, rs2_val, imm_sext;

    assign opcode   = inst_q[6:0];
    assign rd       = inst_q[11:7];
    assign funct3   = inst_q[14:12];
    assign rs1      = inst_q[19:15];
    assign rs2      = inst_q[24:20];
    assign imm_sext = {{(XLEN-12){inst_q[31]}}, inst_q[31:20]};

    // x0 is hard-wired to zero; writes land at the end of RETIRE, before any later EXEC reads.
    assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[cur_tid_q][rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[cur_tid_q][rs2];

    logic [N_THREADS-1:0] eligible;
    logic                 sel_found;
    logic [TID_W-1:0]     sel_tid;
    int                   sel_idx;

    assign eligible = thread_en & ~halted_q;

    // Round-robin pick: first eligible thread at or above rr pointer, wrapping; scanning down keeps the closest.
    always_comb begin
        sel_found = 1'b0;
        sel_tid   = '0;
        sel_idx   = 0;
        for (int i = N_THREADS - 1; i >= 0; i--) begin
            sel_idx = (int'(rr_q) + i) % N_THREADS;
            if (eligible[TID_W'(sel_idx)]) begin
                sel_found = 1'b1;
                sel_tid   = TID_W'(sel_idx);
            end
        end
    end

    // Next-state and unit-port outputs; fetch and execute requests run back to back to keep 4 cycles/instruction.
    always_comb begin
        state_d   = state_q;
        cur_tid_d = cur_tid_q;
        rr_d      = rr_q;
        halted_d  = halted_q;
        inst_d    = inst_q;
        result_d  = result_q;
        pc_inc    = 1'b0;
        rf_we     = 1'b0;
        retire    = 1'b0;
        u_sel     = UNIT_SEL_RAM;
        u_contr   = '0;
        u_in0     = '0;
        u_in1     = '0;
        u_req     = 1'b0;
        case (state_q)
            ST_SELECT: begin
                if (sel_found) begin
                    cur_tid_d = sel_tid;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                u_req   = 1'b1;
                u_sel   = UNIT_SEL_RAM;
                u_contr = XLEN'(RAM_CTRL_READ);
                u_in0   = pc_q[cur_tid_q];
                if (unit.unit_ack) begin
                    inst_d  = unit.unit_out[31:0];
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    OPC_OP, OPC_OP_IMM: begin
                        u_req = 1'b1;
                        u_sel = UNIT_SEL_ALU;
                        u_in0 = rs1_val;
                        if (opcode == OPC_OP) begin
                            u_contr = XLEN'({inst_q[30], funct3});
                            u_in1   = rs2_val;
                        end else begin
                            // Only the shift-right immediates carry the arithmetic/logical select in bit 30.
                            u_contr = XLEN'({(funct3 == 3'b101) & inst_q[30], funct3});
                            u_in1   = imm_sext;
                        end
                        if (unit.unit_ack) begin
                            result_d = unit.unit_out;
                            state_d  = ST_RETIRE;
                        end
                    end
                    OPC_LUI: begin
                        result_d = XLEN'({inst_q[31:12], 12'b0});
                        state_d  = ST_RETIRE;
                    end
                    default: begin
                        halted_d[cur_tid_q] = 1'b1;
                        state_d             = ST_SELECT;
                    end
                endcase
            end
            ST_RETIRE: begin
                retire  = 1'b1;
                pc_inc  = 1'b1;
                rf_we   = (rd != 5'd0);
                rr_d    = (cur_tid_q == TID_W'(N_THREADS - 1)) ? '0 : TID_W'(cur_tid_q + 1'b1);
                state_d = ST_SELECT;
            end
            default: state_d = ST_SELECT;
        endcase
    end

    // Control state, per-thread pcs and halt flags; reset drops req at once since req decodes from state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_SELECT;
            cur_tid_q <= '0;
            rr_q      <= '0;
            halted_q  <= '0;
            inst_q    <= '0;
            result_q  <= '0;
            for (int t = 0; t < N_THREADS; t++) begin
                pc_q[t] <= RESET_PC + XLEN'(t) * PC_STRIDE;
            end
        end else begin
            state_q   <= state_d;
            cur_tid_q <= cur_tid_d;
            rr_q      <= rr_d;
            halted_q  <= halted_d;
            inst_q    <= inst_d;
            result_q  <= result_d;
            if (pc_inc) begin
                pc_q[cur_tid_q] <= pc_q[cur_tid_q] + XLEN'(4);
            end
        end
    end

    // Per-thread register files hold no reset value; only retirement writes them.
    always_ff @(posedge clk) begin
        if (rf_we) begin
            rf_q[cur_tid_q][rd] <= result_q;
        end
    end

    assign unit.unit_sel   = u_sel;
    assign unit.unit_contr = u_contr;
    assign unit.unit_in0   = u_in0;
    assign unit.unit_in1   = u_in1;
    assign unit.unit_req   = u_req;

    assign cur_tid = cur_tid_q;
    assign halted  = halted_q;
endmodule

// File: tb/tb_thread_sched.sv
// Directed bench for thread_sched: bench-side RAM/ALU responder with programmable ack delay.
// Latency: checks retire spacing, issue order, halts, stability of held requests, pc wrap.
// Backpressure: responder stalls ack by ack_delay cycles per request.
module tb_thread_sched;
    import thread_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  thread_en = '0;
    logic [1:0]  cur_tid;
    logic        retire;
    logic [3:0]  halted;

    logic [0:0]  en2 = '0;
    logic [0:0]  cur_tid2;
    logic        retire2;
    logic [0:0]  halted2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int req_hi  = 0;
    int ack_delay = 0;
    int wcnt    = 0;
    int r2cnt   = 0;
    int tid_q[$];
    int cyc_q[$];
    logic [31:0] fa2[$];
    logic [31:0] imem [logic [31:0]];

    unit_sel_t   snap_sel;
    logic [31:0] snap_contr, snap_in0, snap_in1;

    always #5 clk = ~clk;

    thread_sched_if #(.XLEN(32)) ubus ();
    thread_sched_if #(.XLEN(32)) ubus2 ();

    thread_sched #(.N_THREADS(4), .XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .thread_en (thread_en),
        .unit      (ubus.master),
        .cur_tid   (cur_tid),
        .retire    (retire),
        .halted    (halted)
    );

    thread_sched #(.N_THREADS(1), .XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .thread_en (en2),
        .unit      (ubus2.master),
        .cur_tid   (cur_tid2),
        .retire    (retire2),
        .halted    (halted2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%08h, expected 'h%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return {31'b0, $signed(a) < $signed(b)};
            4'b0011: return {31'b0, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return 32'($signed(a) >>> b[4:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [31:0] fetch(input logic [31:0] addr);
        if (imem.exists(addr)) return imem[addr];
        return 32'h0000_0013;  // addi x0,x0,0
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Retire and request-occupancy monitor.
    always @(negedge clk) begin
        if (retire) begin
            tid_q.push_back(int'(cur_tid));
            cyc_q.push_back(cyc);
        end
        if (ubus.unit_req) req_hi++;
        if (retire2) r2cnt++;
        if (ubus2.unit_req && ubus2.unit_sel == UNIT_SEL_RAM) fa2.push_back(ubus2.unit_in0);
    end

    // Unit model for the 4-thread instance: delayed ack, request fields must hold while waiting.
    initial begin
        ubus.unit_ack = 1'b0;
        ubus.unit_out = '0;
        forever begin
            @(negedge clk);
            if (ubus.unit_req) begin
                if (wcnt == 0) begin
                    snap_sel   = ubus.unit_sel;
                    snap_contr = ubus.unit_contr;
                    snap_in0   = ubus.unit_in0;
                    snap_in1   = ubus.unit_in1;
                    if (ubus.unit_sel == UNIT_SEL_RAM) begin
                        check("fetch_contr", ubus.unit_contr, RAM_CTRL_READ);
                        check("fetch_in1", ubus.unit_in1, 32'h0);
                    end
                end else begin
                    check("stable_sel", 32'(ubus.unit_sel), 32'(snap_sel));
                    check("stable_contr", ubus.unit_contr, snap_contr);
                    check("stable_in0", ubus.unit_in0, snap_in0);
                    check("stable_in1", ubus.unit_in1, snap_in1);
                end
                if (wcnt == ack_delay) begin
                    ubus.unit_ack = 1'b1;
                    ubus.unit_out = (ubus.unit_sel == UNIT_SEL_RAM) ? fetch(ubus.unit_in0)
                                  : alu(ubus.unit_contr[3:0], ubus.unit_in0, ubus.unit_in1);
                    wcnt = 0;
                end else begin
                    ubus.unit_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                ubus.unit_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Unit model for the single-thread instance: immediate ack, nop program.
    initial begin
        ubus2.unit_ack = 1'b0;
        ubus2.unit_out = '0;
        forever begin
            @(negedge clk);
            ubus2.unit_ack = ubus2.unit_req;
            ubus2.unit_out = (ubus2.unit_sel == UNIT_SEL_RAM) ? 32'h0000_0013
                           : ubus2.unit_in0 + ubus2.unit_in1;
        end
    end

    task automatic do_reset(input logic [3:0] en);
        rst = 1'b0;
        thread_en = en;
        repeat (2) @(negedge clk);
        tid_q.delete();
        cyc_q.delete();
        fa2.delete();
        req_hi = 0;
        r2cnt  = 0;
        #1 rst = 1'b1;
    endtask

    task automatic wait_retires(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (tid_q.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(tag, tid_q.size(), n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp3a[5];
        int exp3b[3];
        int exp5[7];
        int k;
        exp3a = '{0, 1, 2, 3, 0};
        exp3b = '{0, 2, 0};
        exp5  = '{0, 2, 3, 0, 2, 3, 0};

        // 1: reset state with all threads enabled; nothing may be requested while rst is low.
        rst = 1'b0;
        thread_en = 4'hF;
        #2;
        repeat (3) begin
            @(negedge clk);
            check("rst_req", 32'(ubus.unit_req), 32'h0);
        end
        check("rst_retire", 32'(retire), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_tid", 32'(cur_tid), 32'h0);
        check("rst_sel", 32'(ubus.unit_sel), 32'(UNIT_SEL_RAM));
        check("rst_in0", ubus.unit_in0, 32'h0);
        check("rst_pc0", dut.pc_q[0], 32'h0000_0000);
        check("rst_pc1", dut.pc_q[1], 32'h0000_1000);
        check("rst_pc2", dut.pc_q[2], 32'h0000_2000);
        check("rst_pc3", dut.pc_q[3], 32'h0000_3000);

        // 2: addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; then sub x5,x3,x1.
        imem.delete();
        imem[32'd0]  = 32'h0050_0093;
        imem[32'd4]  = 32'h0070_0113;
        imem[32'd8]  = 32'h0020_81B3;
        imem[32'd12] = 32'h4011_82B3;
        ack_delay = 0;
        do_reset(4'b0001);
        wait_retires("t2_retires3", 3, 40);
        thread_en = 4'b0000;
        check("t2_gap01", cyc_q[1] - cyc_q[0], 32'd4);
        check("t2_gap12", cyc_q[2] - cyc_q[1], 32'd4);
        repeat (4) @(negedge clk);
        check("t2_no_extra", tid_q.size(), 32'd3);
        check("t2_x1", dut.rf_q[0][1], 32'd5);
        check("t2_x2", dut.rf_q[0][2], 32'd7);
        check("t2_x3", dut.rf_q[0][3], 32'd12);
        check("t2_pc", dut.pc_q[0], 32'd12);
        thread_en = 4'b0001;
        wait_retires("t2_retires4", 4, 20);
        thread_en = 4'b0000;
        repeat (3) @(negedge clk);
        check("t2_x5_sub", dut.rf_q[0][5], 32'd7);
        check("t2_pc16", dut.pc_q[0], 32'd16);

        // 3: round-robin order, all enabled then only threads 0 and 2.
        imem.delete();
        do_reset(4'b1111);
        wait_retires("t3_retires", 5, 60);
        thread_en = 4'b0000;
        for (int i = 0; i < 5; i++) check("t3_tid_all", tid_q[i], exp3a[i]);
        do_reset(4'b0101);
        wait_retires("t3_retires_0101", 3, 40);
        thread_en = 4'b0000;
        for (int i = 0; i < 3; i++) check("t3_tid_0101", tid_q[i], exp3b[i]);

        // 4: ack delayed 5 cycles on both requests; addi x1,x0,-9 checks sign extension.
        imem.delete();
        imem[32'd0] = 32'hFF70_0093;
        ack_delay = 5;
        do_reset(4'b0001);
        wait_retires("t4_retire", 1, 60);
        thread_en = 4'b0000;
        repeat (20) @(negedge clk);
        check("t4_one_retire", tid_q.size(), 32'd1);
        check("t4_req_cycles", req_hi, 32'd12);
        check("t4_x1", dut.rf_q[0][1], 32'hFFFF_FFF7);
        check("t4_pc", dut.pc_q[0], 32'd4);
        // Reset in the middle of a stalled fetch must drop req without waiting for a clock.
        thread_en = 4'b0001;
        k = 0;
        while (!ubus.unit_req && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("t4_req_up", 32'(ubus.unit_req), 32'h1);
        #1 rst = 1'b0;
        #1 check("t4_rst_drops_req", 32'(ubus.unit_req), 32'h0);
        ack_delay = 0;

        // 5: unsupported opcode on T1 halts it; the others keep rotating.
        imem.delete();
        imem[32'h1000] = 32'h0000_006F;
        do_reset(4'b1111);
        wait_retires("t5_retires", 7, 100);
        thread_en = 4'b0000;
        for (int i = 0; i < 7; i++) check("t5_tid", tid_q[i], exp5[i]);
        check("t5_halted", 32'(halted), 32'h2);
        check("t5_pc1_held", dut.pc_q[1], 32'h0000_1000);

        // 6: lui into x0 is discarded; lui x7 writes; pc wraps on the single-thread instance.
        imem.delete();
        imem[32'd0] = 32'hABCD_E037;
        imem[32'd4] = 32'h0000_0233;
        imem[32'd8] = 32'h1234_53B7;
        do_reset(4'b0001);
        wait_retires("t6_retires", 3, 40);
        thread_en = 4'b0000;
        repeat (3) @(negedge clk);
        check("t6_x4", dut.rf_q[0][4], 32'h0);
        check("t6_x7", dut.rf_q[0][7], 32'h1234_5000);
        check("t6_pc", dut.pc_q[0], 32'd12);
        en2 = 1'b1;
        k = 0;
        while (r2cnt < 1 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        en2 = 1'b0;
        check("t6_d2_retire", r2cnt, 32'd1);
        repeat (3) @(negedge clk);
        check("t6_d2_fetch0", fa2[0], 32'hFFFF_FFFC);
        check("t6_d2_pc_wrap", dut2.pc_q[0], 32'h0);
        en2 = 1'b1;
        k = 0;
        while (r2cnt < 2 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        en2 = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_d2_fetch1", fa2[1], 32'h0);
        check("t6_d2_pc4", dut2.pc_q[0], 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
